// File: rtl/biriscv_csr_wb_pipe.sv
// CSR-unit writeback pipeline: carries registered E1 CSR results through E2 and WB,
// merges late LSU faults, and produces the CSR/register-file write strobes and exception report.
module biriscv_csr_wb_pipe (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        e1_valid_i,
    input  logic [31:0] e1_pc_i,
    input  logic [31:0] e1_opcode_i,
    input  logic [4:0]  e1_rd_idx_i,
    input  logic        e1_csr_write_i,
    input  logic [31:0] e1_csr_wdata_i,
    input  logic [31:0] e1_value_i,
    input  logic [5:0]  e1_exception_i,

    input  logic [5:0]  e2_lsu_exception_i,
    input  logic [31:0] e2_lsu_badaddr_i,
    input  logic        stall_i,
    input  logic        squash_i,

    output logic        wb_csr_write_o,
    output logic [11:0] wb_csr_waddr_o,
    output logic [31:0] wb_csr_wdata_o,
    output logic [5:0]  wb_exception_o,
    output logic [31:0] wb_exception_pc_o,
    output logic [31:0] wb_exception_addr_o,

    output logic        wb_rd_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_rd_value_o,
    output logic        wb_retire_o,
    output logic        exception_pending_o
);

    logic        e2_valid_q,      e2_valid_d;
    logic [31:0] e2_pc_q,         e2_pc_d;
    logic [31:0] e2_opcode_q,     e2_opcode_d;
    logic [4:0]  e2_rd_idx_q,     e2_rd_idx_d;
    logic        e2_csr_write_q,  e2_csr_write_d;
    logic [31:0] e2_csr_wdata_q,  e2_csr_wdata_d;
    logic [31:0] e2_value_q,      e2_value_d;
    logic [5:0]  e2_exception_q,  e2_exception_d;

    logic        wb_valid_q,      wb_valid_d;
    logic        wb_csr_write_q,  wb_csr_write_d;
    logic [11:0] wb_csr_waddr_q,  wb_csr_waddr_d;
    logic [31:0] wb_csr_wdata_q,  wb_csr_wdata_d;
    logic [5:0]  wb_exception_q,  wb_exception_d;
    logic [31:0] wb_exc_pc_q,     wb_exc_pc_d;
    logic [31:0] wb_exc_addr_q,   wb_exc_addr_d;
    logic        wb_rd_valid_q,   wb_rd_valid_d;
    logic [4:0]  wb_rd_idx_q,     wb_rd_idx_d;
    logic [31:0] wb_rd_value_q,   wb_rd_value_d;
    logic        wb_retire_q,     wb_retire_d;

    logic        e2_advance;
    logic        lsu_fault;
    logic [5:0]  merged_exc;
    logic        wb_exc_live;

    // LSU fault is only considered for a valid E2 entry that is moving into WB
    // and has no earlier exception of its own.
    assign e2_advance  = e2_valid_q && !stall_i;
    assign lsu_fault   = e2_advance && (e2_exception_q == 6'd0) && (e2_lsu_exception_i != 6'd0);
    assign merged_exc  = (e2_exception_q != 6'd0) ? e2_exception_q :
                         (lsu_fault ? e2_lsu_exception_i : 6'd0);
    assign wb_exc_live = wb_valid_q && (wb_exception_q != 6'd0);

    // E2 next state: squash or a faulting WB flushes E2, stall holds it,
    // and a faulting E2 leaving for WB drops whatever E1 offers behind it.
    always_comb begin
        e2_valid_d     = e2_valid_q;
        e2_pc_d        = e2_pc_q;
        e2_opcode_d    = e2_opcode_q;
        e2_rd_idx_d    = e2_rd_idx_q;
        e2_csr_write_d = e2_csr_write_q;
        e2_csr_wdata_d = e2_csr_wdata_q;
        e2_value_d     = e2_value_q;
        e2_exception_d = e2_exception_q;
        if (squash_i || wb_exc_live) begin
            e2_valid_d = 1'b0;
        end else if (stall_i) begin
            e2_valid_d = e2_valid_q;
        end else if (e2_valid_q && (merged_exc != 6'd0)) begin
            e2_valid_d = 1'b0;
        end else begin
            e2_valid_d     = e1_valid_i;
            e2_pc_d        = e1_pc_i;
            e2_opcode_d    = e1_opcode_i;
            e2_rd_idx_d    = e1_rd_idx_i;
            e2_csr_write_d = e1_csr_write_i;
            e2_csr_wdata_d = e1_csr_wdata_i;
            e2_value_d     = e1_value_i;
            e2_exception_d = e1_exception_i;
        end
    end

    // WB next state: a bubble clears every field so outputs read zero between instructions.
    always_comb begin
        wb_valid_d     = 1'b0;
        wb_csr_write_d = 1'b0;
        wb_csr_waddr_d = 12'd0;
        wb_csr_wdata_d = 32'd0;
        wb_exception_d = 6'd0;
        wb_exc_pc_d    = 32'd0;
        wb_exc_addr_d  = 32'd0;
        wb_rd_valid_d  = 1'b0;
        wb_rd_idx_d    = 5'd0;
        wb_rd_value_d  = 32'd0;
        wb_retire_d    = 1'b0;
        if (e2_advance) begin
            wb_valid_d     = 1'b1;
            wb_csr_write_d = e2_csr_write_q && !lsu_fault;
            wb_csr_waddr_d = e2_opcode_q[31:20];
            wb_csr_wdata_d = e2_csr_wdata_q;
            wb_exception_d = merged_exc;
            wb_exc_pc_d    = (merged_exc != 6'd0) ? e2_pc_q : 32'd0;
            wb_exc_addr_d  = (e2_exception_q != 6'd0) ? e2_value_q :
                             (lsu_fault ? e2_lsu_badaddr_i : 32'd0);
            wb_rd_valid_d  = e2_csr_write_q && (e2_rd_idx_q != 5'd0) && !lsu_fault;
            wb_rd_idx_d    = e2_rd_idx_q;
            wb_rd_value_d  = e2_value_q;
            wb_retire_d    = (merged_exc == 6'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e2_valid_q     <= 1'b0;
            e2_pc_q        <= 32'd0;
            e2_opcode_q    <= 32'd0;
            e2_rd_idx_q    <= 5'd0;
            e2_csr_write_q <= 1'b0;
            e2_csr_wdata_q <= 32'd0;
            e2_value_q     <= 32'd0;
            e2_exception_q <= 6'd0;
            wb_valid_q     <= 1'b0;
            wb_csr_write_q <= 1'b0;
            wb_csr_waddr_q <= 12'd0;
            wb_csr_wdata_q <= 32'd0;
            wb_exception_q <= 6'd0;
            wb_exc_pc_q    <= 32'd0;
            wb_exc_addr_q  <= 32'd0;
            wb_rd_valid_q  <= 1'b0;
            wb_rd_idx_q    <= 5'd0;
            wb_rd_value_q  <= 32'd0;
            wb_retire_q    <= 1'b0;
        end else begin
            e2_valid_q     <= e2_valid_d;
            e2_pc_q        <= e2_pc_d;
            e2_opcode_q    <= e2_opcode_d;
            e2_rd_idx_q    <= e2_rd_idx_d;
            e2_csr_write_q <= e2_csr_write_d;
            e2_csr_wdata_q <= e2_csr_wdata_d;
            e2_value_q     <= e2_value_d;
            e2_exception_q <= e2_exception_d;
            wb_valid_q     <= wb_valid_d;
            wb_csr_write_q <= wb_csr_write_d;
            wb_csr_waddr_q <= wb_csr_waddr_d;
            wb_csr_wdata_q <= wb_csr_wdata_d;
            wb_exception_q <= wb_exception_d;
            wb_exc_pc_q    <= wb_exc_pc_d;
            wb_exc_addr_q  <= wb_exc_addr_d;
            wb_rd_valid_q  <= wb_rd_valid_d;
            wb_rd_idx_q    <= wb_rd_idx_d;
            wb_rd_value_q  <= wb_rd_value_d;
            wb_retire_q    <= wb_retire_d;
        end
    end

    assign wb_csr_write_o      = wb_csr_write_q;
    assign wb_csr_waddr_o      = wb_csr_waddr_q;
    assign wb_csr_wdata_o      = wb_csr_wdata_q;
    assign wb_exception_o      = wb_exception_q;
    assign wb_exception_pc_o   = wb_exc_pc_q;
    assign wb_exception_addr_o = wb_exc_addr_q;
    assign wb_rd_valid_o       = wb_rd_valid_q;
    assign wb_rd_idx_o         = wb_rd_idx_q;
    assign wb_rd_value_o       = wb_rd_value_q;
    assign wb_retire_o         = wb_retire_q;

    // Gated by rst_n so an E1 fault presented during reset does not leak out.
    assign exception_pending_o = rst_n &&
                                 ((e2_valid_q && (e2_exception_q != 6'd0)) ||
                                  wb_exc_live ||
                                  (e1_valid_i && (e1_exception_i != 6'd0)));

endmodule

// File: tb/tb_biriscv_csr_wb_pipe.sv
// Scoreboard bench for biriscv_csr_wb_pipe: stimulus pushes expected WB records,
// a negedge monitor pops them whenever WB presents an instruction and checks bubbles are all-zero.
module tb_biriscv_csr_wb_pipe;

    logic        clk;
    logic        rst_n;
    logic        e1_valid_i;
    logic [31:0] e1_pc_i;
    logic [31:0] e1_opcode_i;
    logic [4:0]  e1_rd_idx_i;
    logic        e1_csr_write_i;
    logic [31:0] e1_csr_wdata_i;
    logic [31:0] e1_value_i;
    logic [5:0]  e1_exception_i;
    logic [5:0]  e2_lsu_exception_i;
    logic [31:0] e2_lsu_badaddr_i;
    logic        stall_i;
    logic        squash_i;
    logic        wb_csr_write_o;
    logic [11:0] wb_csr_waddr_o;
    logic [31:0] wb_csr_wdata_o;
    logic [5:0]  wb_exception_o;
    logic [31:0] wb_exception_pc_o;
    logic [31:0] wb_exception_addr_o;
    logic        wb_rd_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_rd_value_o;
    logic        wb_retire_o;
    logic        exception_pending_o;

    int checks;
    int errors;
    logic [153:0] expQ[$];
    logic [153:0] actualVec;

    biriscv_csr_wb_pipe dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .e1_valid_i          (e1_valid_i),
        .e1_pc_i             (e1_pc_i),
        .e1_opcode_i         (e1_opcode_i),
        .e1_rd_idx_i         (e1_rd_idx_i),
        .e1_csr_write_i      (e1_csr_write_i),
        .e1_csr_wdata_i      (e1_csr_wdata_i),
        .e1_value_i          (e1_value_i),
        .e1_exception_i      (e1_exception_i),
        .e2_lsu_exception_i  (e2_lsu_exception_i),
        .e2_lsu_badaddr_i    (e2_lsu_badaddr_i),
        .stall_i             (stall_i),
        .squash_i            (squash_i),
        .wb_csr_write_o      (wb_csr_write_o),
        .wb_csr_waddr_o      (wb_csr_waddr_o),
        .wb_csr_wdata_o      (wb_csr_wdata_o),
        .wb_exception_o      (wb_exception_o),
        .wb_exception_pc_o   (wb_exception_pc_o),
        .wb_exception_addr_o (wb_exception_addr_o),
        .wb_rd_valid_o       (wb_rd_valid_o),
        .wb_rd_idx_o         (wb_rd_idx_o),
        .wb_rd_value_o       (wb_rd_value_o),
        .wb_retire_o         (wb_retire_o),
        .exception_pending_o (exception_pending_o)
    );

    assign actualVec = {wb_csr_write_o, wb_csr_waddr_o, wb_csr_wdata_o, wb_exception_o,
                        wb_exception_pc_o, wb_exception_addr_o, wb_rd_valid_o,
                        wb_rd_idx_o, wb_rd_value_o, wb_retire_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [153:0] pack(input logic csrw, input logic [11:0] waddr,
                                          input logic [31:0] wdata, input logic [5:0] exc,
                                          input logic [31:0] epc, input logic [31:0] eaddr,
                                          input logic rdv, input logic [4:0] rd,
                                          input logic [31:0] rdval, input logic ret);
        return {csrw, waddr, wdata, exc, epc, eaddr, rdv, rd, rdval, ret};
    endfunction

    task automatic checkOutput(input string name, input logic [153:0] actual,
                               input logic [153:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; control lines default low every cycle.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] op,
                                 input logic [4:0] rd, input logic csrw,
                                 input logic [31:0] wdata, input logic [31:0] value,
                                 input logic [5:0] exc);
        @(posedge clk);
        #1;
        e1_valid_i         = v;
        e1_pc_i            = pc;
        e1_opcode_i        = op;
        e1_rd_idx_i        = rd;
        e1_csr_write_i     = csrw;
        e1_csr_wdata_i     = wdata;
        e1_value_i         = value;
        e1_exception_i     = exc;
        stall_i            = 1'b0;
        squash_i           = 1'b0;
        e2_lsu_exception_i = 6'd0;
        e2_lsu_badaddr_i   = 32'd0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 6'd0);
    endtask

    // Monitor: an instruction is presented when it retires or reports an exception.
    always @(negedge clk) begin
        if (wb_retire_o || (wb_exception_o != 6'd0)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb: got %h expected no instruction", actualVec);
            end else begin
                checkOutput("wb_record", actualVec, expQ.pop_front());
            end
        end else begin
            checkOutput("wb_bubble", actualVec, 154'd0);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        e1_valid_i = 1'b1; e1_pc_i = 32'h0; e1_opcode_i = 32'h0; e1_rd_idx_i = 5'd0;
        e1_csr_write_i = 1'b0; e1_csr_wdata_i = 32'd0; e1_value_i = 32'd0;
        e1_exception_i = 6'h12; e2_lsu_exception_i = 6'd0; e2_lsu_badaddr_i = 32'd0;
        stall_i = 1'b0; squash_i = 1'b0;
        #3;
        checkOutput("reset_outputs", actualVec, 154'd0);
        checkOutput("reset_pending", {153'd0, exception_pending_o}, 154'd0);
        idleCycle();
        idleCycle();
        rst_n = 1'b1;
        idleCycle();

        // Basic CSR writes, one to x0, plus a pure CSR read with no write.
        applyStimulus(1, 32'h100, 32'h30029073, 5'd5, 1, 32'h8, 32'h1800, 6'd0);
        expQ.push_back(pack(1, 12'h300, 32'h8, 6'd0, 32'd0, 32'd0, 1, 5'd5, 32'h1800, 1));
        idleCycle();
        idleCycle();
        checkOutput("latency_n2", {153'd0, wb_retire_o}, 154'd1);
        idleCycle();
        checkOutput("latency_n3", {153'd0, wb_retire_o}, 154'd0);
        applyStimulus(1, 32'h104, 32'h34001073, 5'd0, 1, 32'h5A, 32'h9, 6'd0);
        expQ.push_back(pack(1, 12'h340, 32'h5A, 6'd0, 32'd0, 32'd0, 0, 5'd0, 32'h9, 1));
        applyStimulus(1, 32'h120, 32'hF1402573, 5'd10, 0, 32'h0, 32'h0, 6'd0);
        expQ.push_back(pack(0, 12'hF14, 32'h0, 6'd0, 32'd0, 32'd0, 0, 5'd10, 32'h0, 1));
        repeat (3) idleCycle();

        // LSU fault merged in E2 suppresses writes and drops the trailing E1 instruction.
        applyStimulus(1, 32'h200, 32'h34051573, 5'd10, 1, 32'h77, 32'h55, 6'd0);
        expQ.push_back(pack(0, 12'h340, 32'h77, 6'h15, 32'h200, 32'h80001000, 0, 5'd10, 32'h55, 0));
        applyStimulus(1, 32'h204, 32'h30029073, 5'd3, 1, 32'h1, 32'h2, 6'd0);
        e2_lsu_exception_i = 6'h15;
        e2_lsu_badaddr_i   = 32'h80001000;
        repeat (4) idleCycle();

        // E1 exception takes priority over a concurrent LSU fault; pending spans E1..WB.
        applyStimulus(1, 32'h300, 32'hFFFFFFFF, 5'd0, 0, 32'h0, 32'hFFFFFFFF, 6'h12);
        expQ.push_back(pack(0, 12'hFFF, 32'h0, 6'h12, 32'h300, 32'hFFFFFFFF, 0, 5'd0, 32'hFFFFFFFF, 0));
        #1 checkOutput("pending_e1", {153'd0, exception_pending_o}, 154'd1);
        idleCycle();
        e2_lsu_exception_i = 6'h15;
        e2_lsu_badaddr_i   = 32'h1234;
        #1 checkOutput("pending_e2", {153'd0, exception_pending_o}, 154'd1);
        idleCycle();
        #1 checkOutput("pending_wb", {153'd0, exception_pending_o}, 154'd1);
        idleCycle();
        #1 checkOutput("pending_clear", {153'd0, exception_pending_o}, 154'd0);
        repeat (2) idleCycle();

        // An E1 exception still lets its CSR write through.
        applyStimulus(1, 32'h310, 32'h18051073, 5'd0, 1, 32'h80000001, 32'h0, 6'h02);
        expQ.push_back(pack(1, 12'h180, 32'h80000001, 6'h02, 32'h310, 32'h0, 0, 5'd0, 32'h0, 0));
        repeat (4) idleCycle();

        // Three-cycle stall with an instruction parked in E2.
        applyStimulus(1, 32'h400, 32'h30531073, 5'd6, 1, 32'h1, 32'h2, 6'd0);
        expQ.push_back(pack(1, 12'h305, 32'h1, 6'd0, 32'd0, 32'd0, 1, 5'd6, 32'h2, 1));
        repeat (3) begin
            idleCycle();
            stall_i = 1'b1;
        end
        repeat (4) idleCycle();

        // Squash arriving during a stall kills the parked instruction.
        applyStimulus(1, 32'h440, 32'h30029073, 5'd9, 1, 32'h3, 32'h4, 6'd0);
        idleCycle();
        stall_i = 1'b1;
        idleCycle();
        stall_i  = 1'b1;
        squash_i = 1'b1;
        repeat (4) idleCycle();

        // Squash alone: E2 still reaches WB, incoming E1 is dropped.
        applyStimulus(1, 32'h500, 32'h34129073, 5'd5, 1, 32'h10, 32'h20, 6'd0);
        expQ.push_back(pack(1, 12'h341, 32'h10, 6'd0, 32'd0, 32'd0, 1, 5'd5, 32'h20, 1));
        applyStimulus(1, 32'h504, 32'h30029073, 5'd4, 1, 32'h11, 32'h21, 6'd0);
        squash_i = 1'b1;
        repeat (4) idleCycle();

        // Reset while both stages are occupied discards everything.
        applyStimulus(1, 32'h700, 32'h30029073, 5'd1, 1, 32'hA, 32'hB, 6'd0);
        applyStimulus(1, 32'h704, 32'h30029073, 5'd2, 1, 32'hC, 32'hD, 6'd0);
        idleCycle();
        rst_n          = 1'b0;
        e1_valid_i     = 1'b1;
        e1_exception_i = 6'h05;
        #1;
        checkOutput("reset_mid_outputs", actualVec, 154'd0);
        checkOutput("reset_mid_pending", {153'd0, exception_pending_o}, 154'd0);
        idleCycle();
        idleCycle();
        rst_n = 1'b1;
        repeat (4) idleCycle();
        applyStimulus(1, 32'h600, 32'h30029073, 5'd7, 1, 32'h3, 32'h4, 6'd0);
        expQ.push_back(pack(1, 12'h300, 32'h3, 6'd0, 32'd0, 32'd0, 1, 5'd7, 32'h4, 1));
        repeat (5) idleCycle();

        checkOutput("scoreboard_drained", {122'd0, 32'(expQ.size())}, 154'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
